// File: rtl/jtvigil_objbuf_if.sv
// Object line buffer bus: drawer write port, mixer read port and line-blank/flip controls.
// Ports (signals):
//   LHBL    horizontal blank, active low; its falling edge swaps banks
//   flip    screen flip, inverts the read address
//   wr_addr / wr_data / we   drawer pixel write
//   rd_addr / rd             mixer pixel read (h counter / pxl_cen)
//   rd_data                  registered pixel to the mixer, 8'h00 = no object
// Modports: master drives the controls and reads rd_data, slave is the buffer side.
interface jtvigil_objbuf_if #(
    parameter int AW = 9,
    parameter int DW = 8
);
    logic          LHBL;
    logic          flip;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          we;
    logic [AW-1:0] rd_addr;
    logic          rd;
    logic [DW-1:0] rd_data;

    modport master (
        output LHBL, flip, wr_addr, wr_data, we, rd_addr, rd,
        input  rd_data
    );

    modport slave (
        input  LHBL, flip, wr_addr, wr_data, we, rd_addr, rd,
        output rd_data
    );
endinterface

// File: rtl/jtvigil_objbuf.sv
// Double-buffered object line buffer. The drawer composes one line into the write bank
// (sel) while the mixer plays back the other bank (~sel); every read erases its entry on
// the following clock so the bank is clean for its next composition pass.
// Ports:
//   clk    video clock, all logic on posedge
//   rst_n  asynchronous active-low reset
//   bus    jtvigil_objbuf_if slave: LHBL, flip, wr_addr, wr_data, we, rd_addr, rd, rd_data
// Optional feature: define JTVIGIL_OBJBUF_PRIO_EN to keep a per-entry occupied flag so the
// first object written to a pixel wins; otherwise later writes overwrite earlier ones.
module jtvigil_objbuf #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input logic              clk,
    input logic              rst_n,
    jtvigil_objbuf_if.slave  bus
);
    localparam int Depth = 1 << AW;

    // Both banks live in one array; the top index bit is the bank.
    logic [DW-1:0] mem [2*Depth];

    logic          sel;
    logic          lhbl_l;
    logic          erase_pend;
    logic [AW:0]   erase_idx;
    logic [DW-1:0] rd_data_q;

    logic          swap;
    logic [AW-1:0] rd_eff;
    logic [AW:0]   wr_idx;
    logic [AW:0]   rd_idx;
    logic          wr_en;

`ifdef JTVIGIL_OBJBUF_PRIO_EN
    logic [2*Depth-1:0] flags;
`endif

    always_comb begin
        swap   = lhbl_l & ~bus.LHBL;
        rd_eff = bus.flip ? ~bus.rd_addr : bus.rd_addr;
        wr_idx = {sel, bus.wr_addr};
        rd_idx = {~sel, rd_eff};
`ifdef JTVIGIL_OBJBUF_PRIO_EN
        wr_en  = bus.we & (bus.wr_data[3:0] != 4'd0) & ~flags[wr_idx];
`else
        wr_en  = bus.we & (bus.wr_data[3:0] != 4'd0);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= 1'b0;
            lhbl_l     <= 1'b0;
            erase_pend <= 1'b0;
            erase_idx  <= '0;
            rd_data_q  <= '0;
        end else begin
            lhbl_l     <= bus.LHBL;
            // A write in the swap cycle still uses the old sel.
            sel        <= sel ^ swap;
            erase_pend <= bus.rd;
            if (bus.rd) begin
                erase_idx <= rd_idx;
                rd_data_q <= mem[rd_idx];
            end
        end
    end

    // RAM contents are deliberately not reset. The write is ordered after the erase so the
    // drawer wins if a swap lands the two on the same entry.
    always_ff @(posedge clk) begin
        if (erase_pend) mem[erase_idx] <= '0;
        if (wr_en)      mem[wr_idx]    <= bus.wr_data;
    end

`ifdef JTVIGIL_OBJBUF_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= '0;
        end else begin
            if (erase_pend) flags[erase_idx] <= 1'b0;
            if (wr_en)      flags[wr_idx]    <= 1'b1;
        end
    end
`endif

    assign bus.rd_data = rd_data_q;
endmodule
